jzjpcc_mem_arbiter: RTL and testbench

JZJPCC_MEM_ARBITER -- requirements
Module: jzjpcc_mem_arbiter

---
 rtl/jzjpcc_mem_arbiter.sv | 125 ++++++++++++
 tb/tb_jzjpcc_mem_arbiter.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/jzjpcc_mem_arbiter.sv
// Two-port (load/store + fetch) arbiter onto a single word-wide memory port.
// IDLE -> BUSY_x -> ACK -> IDLE; all outputs are registered.
module jzjpcc_mem_arbiter #(
    parameter int unsigned RR_ENABLE = 1
) (
    input  logic        clock,
    input  logic        reset,

    input  logic        ls_req,
    input  logic        ls_we,
    input  logic [29:0] ls_addr,
    input  logic [31:0] ls_wdata,
    input  logic [3:0]  ls_byteMask,
    output logic        ls_ack,
    output logic [31:0] ls_rdata,

    input  logic        if_req,
    input  logic [29:0] if_addr,
    output logic        if_ack,
    output logic [31:0] if_rdata,

    output logic        mem_req,
    output logic        mem_we,
    output logic [29:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_byteMask,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE,
        BUSY_LS,
        BUSY_IF,
        ACK
    } state_t;

    typedef enum logic {
        PORT_LS,
        PORT_IF
    } port_t;

    state_t state;
    port_t  last_grant;
    logic   rr_on;
    logic   pick_ls;

    assign rr_on = (RR_ENABLE != 0);

    // On a conflict LS wins unless round-robin says it was served last.
    always_comb begin
        pick_ls = 1'b0;
        if (ls_req) begin
            if (!if_req || !rr_on || last_grant == PORT_IF) begin
                pick_ls = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            last_grant   <= PORT_IF;
            mem_req      <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            mem_byteMask <= '0;
            ls_ack       <= 1'b0;
            if_ack       <= 1'b0;
            ls_rdata     <= '0;
            if_rdata     <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    ls_ack <= 1'b0;
                    if_ack <= 1'b0;
                    if (pick_ls) begin
                        state        <= BUSY_LS;
                        mem_req      <= 1'b1;
                        mem_we       <= ls_we;
                        mem_addr     <= ls_addr;
                        mem_wdata    <= ls_wdata;
                        mem_byteMask <= ls_byteMask;
                    end else if (if_req) begin
                        state        <= BUSY_IF;
                        mem_req      <= 1'b1;
                        mem_we       <= 1'b0;
                        mem_addr     <= if_addr;
                        mem_wdata    <= '0;
                        mem_byteMask <= 4'b1111;
                    end
                end
                BUSY_LS: begin
                    if (mem_ready) begin
                        state      <= ACK;
                        mem_req    <= 1'b0;
                        ls_rdata   <= mem_rdata;
                        ls_ack     <= 1'b1;
                        last_grant <= PORT_LS;
                    end
                end
                BUSY_IF: begin
                    if (mem_ready) begin
                        state      <= ACK;
                        mem_req    <= 1'b0;
                        if_rdata   <= mem_rdata;
                        if_ack     <= 1'b1;
                        last_grant <= PORT_IF;
                    end
                end
                ACK: begin
                    // A still-high req is ignored here; it is re-sampled in IDLE.
                    ls_ack <= 1'b0;
                    if_ack <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_jzjpcc_mem_arbiter.sv
// Directed bench: instance a uses round-robin, instance b fixed LS priority.
// Both share all inputs; expected values are hand-computed constants.
module tb_jzjpcc_mem_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic        ls_req;
    logic        ls_we;
    logic [29:0] ls_addr;
    logic [31:0] ls_wdata;
    logic [3:0]  ls_byteMask;
    logic        if_req;
    logic [29:0] if_addr;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    logic        a_ls_ack, a_if_ack, a_mem_req, a_mem_we;
    logic [31:0] a_ls_rdata, a_if_rdata, a_mem_wdata;
    logic [29:0] a_mem_addr;
    logic [3:0]  a_mem_mask;

    logic        b_ls_ack, b_if_ack, b_mem_req, b_mem_we;
    logic [31:0] b_ls_rdata, b_if_rdata, b_mem_wdata;
    logic [29:0] b_mem_addr;
    logic [3:0]  b_mem_mask;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clock = ~clock;

    jzjpcc_mem_arbiter #(.RR_ENABLE(1)) dut_a (
        .clock(clock), .reset(reset),
        .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr),
        .ls_wdata(ls_wdata), .ls_byteMask(ls_byteMask),
        .ls_ack(a_ls_ack), .ls_rdata(a_ls_rdata),
        .if_req(if_req), .if_addr(if_addr),
        .if_ack(a_if_ack), .if_rdata(a_if_rdata),
        .mem_req(a_mem_req), .mem_we(a_mem_we), .mem_addr(a_mem_addr),
        .mem_wdata(a_mem_wdata), .mem_byteMask(a_mem_mask),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata)
    );

    jzjpcc_mem_arbiter #(.RR_ENABLE(0)) dut_b (
        .clock(clock), .reset(reset),
        .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr),
        .ls_wdata(ls_wdata), .ls_byteMask(ls_byteMask),
        .ls_ack(b_ls_ack), .ls_rdata(b_ls_rdata),
        .if_req(if_req), .if_addr(if_addr),
        .if_ack(b_if_ack), .if_rdata(b_if_rdata),
        .mem_req(b_mem_req), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
        .mem_wdata(b_mem_wdata), .mem_byteMask(b_mem_mask),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, " mem_req"}, a_mem_req, 0);
        chk({tag, " mem_we"}, a_mem_we, 0);
        chk({tag, " mem_addr"}, a_mem_addr, 0);
        chk({tag, " mem_wdata"}, a_mem_wdata, 0);
        chk({tag, " mem_mask"}, a_mem_mask, 0);
        chk({tag, " ls_ack"}, a_ls_ack, 0);
        chk({tag, " if_ack"}, a_if_ack, 0);
        chk({tag, " ls_rdata"}, a_ls_rdata, 0);
        chk({tag, " if_rdata"}, a_if_rdata, 0);
        chk({tag, " b_mem_req"}, b_mem_req, 0);
    endtask

    initial begin
        logic ls_turn;
        reset       = 1'b1;
        ls_req      = 1'b0;
        ls_we       = 1'b0;
        ls_addr     = '0;
        ls_wdata    = '0;
        ls_byteMask = '0;
        if_req      = 1'b0;
        if_addr     = '0;
        mem_ready   = 1'b0;
        mem_rdata   = '0;
        tick();
        tick();
        chk_reset_state("rst");
        reset = 1'b0;

        // single fetch, memory always ready
        if_req    = 1'b1;
        if_addr   = 30'h40;
        mem_ready = 1'b1;
        mem_rdata = 32'h0000_0013;
        tick();
        chk("f mem_req", a_mem_req, 1);
        chk("f mem_addr", a_mem_addr, 30'h40);
        chk("f mem_we", a_mem_we, 0);
        chk("f mem_mask", a_mem_mask, 4'b1111);
        chk("f mem_wdata", a_mem_wdata, 0);
        chk("f early ack", a_if_ack, 0);
        tick();
        chk("f if_ack", a_if_ack, 1);
        chk("f if_rdata", a_if_rdata, 32'h13);
        chk("f ls_ack", a_ls_ack, 0);
        chk("f ack mem_req", a_mem_req, 0);
        if_req = 1'b0;
        tick();
        chk("f idle ack", a_if_ack, 0);
        chk("f rdata hold", a_if_rdata, 32'h13);
        chk("f idle req", a_mem_req, 0);

        // store with three wait states, payload changed after grant
        mem_ready   = 1'b0;
        mem_rdata   = 32'h5555_5555;
        ls_req      = 1'b1;
        ls_we       = 1'b1;
        ls_addr     = 30'h100;
        ls_wdata    = 32'hAB00_0000;
        ls_byteMask = 4'b1000;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("s mem_req", a_mem_req, 1);
            chk("s mem_addr", a_mem_addr, 30'h100);
            chk("s mem_we", a_mem_we, 1);
            chk("s mem_wdata", a_mem_wdata, 32'hAB00_0000);
            chk("s mem_mask", a_mem_mask, 4'b1000);
            chk("s ls_ack", a_ls_ack, 0);
            chk("s if_ack", a_if_ack, 0);
            if (i == 0) begin
                ls_addr     = 30'h200;
                ls_wdata    = 32'h1234_5678;
                ls_byteMask = 4'b0001;
            end
            if (i == 3) begin
                mem_ready = 1'b1;
                mem_rdata = 32'hDEAD_BEEF;
            end
        end
        tick();
        chk("s ack", a_ls_ack, 1);
        chk("s ack if", a_if_ack, 0);
        chk("s rdata", a_ls_rdata, 32'hDEAD_BEEF);
        ls_req = 1'b0;
        ls_we  = 1'b0;
        tick();
        chk("s idle ack", a_ls_ack, 0);
        chk("s idle if", a_if_ack, 0);
        chk("s rdata hold", a_ls_rdata, 32'hDEAD_BEEF);

        // conflict from reset release: a alternates, b always LS
        reset = 1'b1;
        #1;
        chk("c rst ls_rdata", a_ls_rdata, 0);
        chk("c rst if_rdata", a_if_rdata, 0);
        tick();
        ls_req      = 1'b1;
        ls_addr     = 30'h11;
        ls_byteMask = 4'b0011;
        if_req      = 1'b1;
        if_addr     = 30'h22;
        mem_ready   = 1'b1;
        reset       = 1'b0;
        for (int k = 0; k < 4; k++) begin
            ls_turn = ((k % 2) == 0);
            tick();
            chk("c a addr", a_mem_addr, ls_turn ? 30'h11 : 30'h22);
            chk("c a mask", a_mem_mask, ls_turn ? 4'b0011 : 4'b1111);
            chk("c b addr", b_mem_addr, 30'h11);
            mem_rdata = 32'h100 + k;
            tick();
            chk("c a ls_ack", a_ls_ack, ls_turn);
            chk("c a if_ack", a_if_ack, !ls_turn);
            chk("c b ls_ack", b_ls_ack, 1);
            chk("c b if_ack", b_if_ack, 0);
            chk("c b ls_rdata", b_ls_rdata, 32'h100 + k);
            if (ls_turn)
                chk("c a ls_rdata", a_ls_rdata, 32'h100 + k);
            else
                chk("c a if_rdata", a_if_rdata, 32'h100 + k);
            tick();
            chk("c a gap", a_ls_ack | a_if_ack, 0);
            chk("c b gap", b_ls_ack | b_if_ack, 0);
        end

        // b serves fetch only once ls_req drops
        ls_req = 1'b0;
        tick();
        chk("p b addr", b_mem_addr, 30'h22);
        chk("p b we", b_mem_we, 0);
        mem_rdata = 32'h0000_0077;
        tick();
        chk("p b if_ack", b_if_ack, 1);
        chk("p b ls_ack", b_ls_ack, 0);
        chk("p b if_rdata", b_if_rdata, 32'h77);
        if_req = 1'b0;
        tick();

        // reset in the middle of a stalled store
        mem_ready   = 1'b0;
        ls_req      = 1'b1;
        ls_we       = 1'b1;
        ls_addr     = 30'h33;
        ls_wdata    = 32'hFFFF_0000;
        ls_byteMask = 4'b1100;
        tick();
        chk("r busy req", a_mem_req, 1);
        chk("r busy addr", a_mem_addr, 30'h33);
        #2;
        reset = 1'b1;
        #1;
        chk_reset_state("r async");
        @(posedge clock);
        #1;
        reset  = 1'b0;
        ls_req = 1'b0;
        ls_we  = 1'b0;
        tick();
        chk("r post req", a_mem_req, 0);
        chk("r post ack", a_ls_ack, 0);
        tick();
        chk("r post ack2", a_ls_ack, 0);
        ls_req    = 1'b1;
        mem_ready = 1'b1;
        mem_rdata = 32'hCAFE_F00D;
        tick();
        chk("r reissue req", a_mem_req, 1);
        chk("r reissue addr", a_mem_addr, 30'h33);
        tick();
        chk("r reissue ack", a_ls_ack, 1);
        chk("r reissue rdata", a_ls_rdata, 32'hCAFE_F00D);
        ls_req = 1'b0;
        tick();
        chk("r final ack", a_ls_ack, 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

    always @(negedge clock) begin
        if (!reset && (a_ls_ack & a_if_ack)) begin
            n_checks++;
            n_errors++;
            $display("FAIL dual_ack: got 1 expected 0");
        end
    end

endmodule
